// File: rtl/pe_types_pkg.sv
// Shared processing-element types: packet format, cluster port encoding and port count.
package pe_types;

  localparam int unsigned CLUSTER_SIDES = 8;

  typedef struct packed {
    logic [3:0]  pid;
    logic [15:0] payload;
  } packet_t;

  // Cluster egress/ingress port identifiers; the value is the port index.
  typedef enum logic [2:0] {
    SR, SL, NR, NL, WL, WR, EL, ER
  } cluster_port_t;

endpackage

// File: rtl/cluster_egress_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr,
// wrapping modulo N. Produces one-hot grant plus its index; no grant unless advance.
module rr_arbiter #(
  parameter int unsigned N = 8,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  // Rotating priority search starting at ptr.
  always_comb begin
    logic [IW-1:0] idx;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    if (advance) begin
      for (int unsigned k = 0; k < N; k++) begin
        idx = IW'((32'(ptr) + k) % N);
        if (!grant_valid && req[idx]) begin
          grant[idx]  = 1'b1;
          grant_idx   = idx;
          grant_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cluster_egress_arbiter.sv
// Drains the cluster egress FIFOs onto one packet stream with round-robin
// arbitration and a single registered output slot (valid/ready).
// Optional per-port saturating grant counters: define CLUSTER_EGRESS_STATS_EN.
module cluster_egress_arbiter
  import pe_types::*;
#(
  parameter int unsigned SIDES  = CLUSTER_SIDES,
  parameter int unsigned STAT_W = 16,
  localparam int unsigned PW = $clog2(SIDES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic    [SIDES-1:0]   egress_empty,
  input  packet_t [SIDES-1:0]   egress_rdata,
  output logic    [SIDES-1:0]   egress_deq,
  output logic                  out_valid,
  input  logic                  out_ready,
  output packet_t               out_pkt,
  output logic    [PW-1:0]      out_port
`ifdef CLUSTER_EGRESS_STATS_EN
  ,
  input  logic    [PW-1:0]      stat_sel,
  output logic    [STAT_W-1:0]  stat_count
`endif
);

  // Counter width is validated in every build so parameter overrides stay portable.
  if (STAT_W == 0) begin : g_stat_w_zero
    $error("STAT_W must be nonzero");
  end

  logic [PW-1:0]    rr_ptr;
  logic             slot_free;
  logic             advance;
  logic [SIDES-1:0] grant;
  logic [PW-1:0]    grant_idx;
  logic             grant_valid;

  assign slot_free = !out_valid || out_ready;
  assign advance   = slot_free && !rst;

  rr_arbiter #(.N(SIDES)) u_rr (
    .req         (~egress_empty),
    .ptr         (rr_ptr),
    .advance     (advance),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign egress_deq = grant;

  // Output slot: load on grant, empty on accept without refill; pointer moves past the winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pkt   <= '0;
      out_port  <= '0;
      rr_ptr    <= '0;
    end else if (grant_valid) begin
      out_valid <= 1'b1;
      out_pkt   <= egress_rdata[grant_idx];
      out_port  <= grant_idx;
      rr_ptr    <= (grant_idx == PW'(SIDES - 1)) ? '0 : grant_idx + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef CLUSTER_EGRESS_STATS_EN
  logic [STAT_W-1:0] stat_cnt [SIDES];

  // Per-port grant counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SIDES; i++) begin
        stat_cnt[i] <= '0;
      end
    end else if (grant_valid && (stat_cnt[grant_idx] != '1)) begin
      stat_cnt[grant_idx] <= stat_cnt[grant_idx] + 1'b1;
    end
  end

  assign stat_count = stat_cnt[stat_sel];
`endif

endmodule

// File: tb/tb_cluster_egress_arbiter.sv
// Directed self-checking bench for cluster_egress_arbiter with a queue model of the upstream FIFOs.
module tb_cluster_egress_arbiter;
  import pe_types::*;

  logic            clk;
  logic            rst;
  logic [7:0]      egress_empty;
  packet_t [7:0]   egress_rdata;
  logic [7:0]      egress_deq;
  logic            out_valid;
  logic            out_ready;
  packet_t         out_pkt;
  logic [2:0]      out_port;

  int checks = 0;
  int errors = 0;

  packet_t q [8][$];

`ifdef CLUSTER_EGRESS_STATS_EN
  logic [2:0] stat_sel;
  logic [3:0] stat_count;

  cluster_egress_arbiter #(.SIDES(8), .STAT_W(4)) dut (
    .clk(clk), .rst(rst), .egress_empty(egress_empty), .egress_rdata(egress_rdata),
    .egress_deq(egress_deq), .out_valid(out_valid), .out_ready(out_ready),
    .out_pkt(out_pkt), .out_port(out_port), .stat_sel(stat_sel), .stat_count(stat_count)
  );
`else
  cluster_egress_arbiter #(.SIDES(8)) dut (
    .clk(clk), .rst(rst), .egress_empty(egress_empty), .egress_rdata(egress_rdata),
    .egress_deq(egress_deq), .out_valid(out_valid), .out_ready(out_ready),
    .out_pkt(out_pkt), .out_port(out_port)
  );
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic refresh();
    for (int i = 0; i < 8; i++) begin
      egress_empty[i] = (q[i].size() == 0);
      egress_rdata[i] = (q[i].size() != 0) ? q[i][0] : '0;
    end
  endtask

  task automatic push(input int p, input logic [15:0] pl);
    packet_t pk;
    pk.pid     = 4'(p);
    pk.payload = pl;
    q[p].push_back(pk);
    refresh();
  endtask

  // One clock: sample dequeue strobes before the edge, then pop the model FIFOs after it.
  task automatic tick();
    logic [7:0] d;
    #2;
    d = egress_deq;
    checks++;
    if (((d & egress_empty) != 8'h00) || ($countones(d) > 1)) begin
      errors++;
      $display("FAIL deq_legal deq=%b empty=%b required one-hot on non-empty port", d, egress_empty);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      if (d[i] && q[i].size() > 0) void'(q[i].pop_front());
    end
    refresh();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    push(3, 16'h0333);
    #1;
    checks++;
    if (egress_deq !== 8'h00) begin
      errors++; $display("FAIL rst_deq_low got=%b required=00000000", egress_deq);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_out_valid got=%b required=0", out_valid);
    end
    checks++;
    if (out_pkt !== packet_t'('0)) begin
      errors++; $display("FAIL rst_out_pkt got=%h required=0", out_pkt);
    end
    checks++;
    if (out_port !== 3'd0) begin
      errors++; $display("FAIL rst_out_port got=%0d required=0", out_port);
    end
    q[3].delete();
    refresh();
    rst = 1'b0;
  endtask

  task automatic test_single();
    packet_t exp;
    exp.pid = 4'd2;
    exp.payload = 16'h00a0;
    out_ready = 1'b1;
    q[5].push_back(exp);
    refresh();
    #1;
    checks++;
    if (egress_deq !== 8'h20) begin
      errors++; $display("FAIL single_deq got=%b required=00100000", egress_deq);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_port !== 3'd5 || out_pkt !== exp) begin
      errors++;
      $display("FAIL single_out valid=%b port=%0d pkt=%h required valid=1 port=5 pkt=%h",
               out_valid, out_port, out_pkt, exp);
    end
    #1;
    checks++;
    if (egress_deq !== 8'h00) begin
      errors++; $display("FAIL single_no_second_deq got=%b required=00000000", egress_deq);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain got=%b required=0", out_valid);
    end
  endtask

  task automatic test_all_ports();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(i, 16'h0010 + 16'(i));
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_port !== 3'(c) || out_pkt.payload !== 16'h0010 + 16'(c)) begin
        errors++;
        $display("FAIL all_ports[%0d] valid=%b port=%0d payload=%h required valid=1 port=%0d payload=%h",
                 c, out_valid, out_port, out_pkt.payload, c, 16'h0010 + 16'(c));
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL all_ports_cycle9 got=%b required=0", out_valid);
    end
  endtask

  task automatic test_fairness();
    logic [2:0]  ep;
    logic [15:0] epl;
    for (int k = 0; k < 4; k++) begin
      push(1, 16'h0100 + 16'(k));
      push(6, 16'h0600 + 16'(k));
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      ep  = (c % 2 == 0) ? 3'd1 : 3'd6;
      epl = ((c % 2 == 0) ? 16'h0100 : 16'h0600) + 16'(c / 2);
      checks++;
      if (out_valid !== 1'b1 || out_port !== ep || out_pkt.payload !== epl) begin
        errors++;
        $display("FAIL fair[%0d] valid=%b port=%0d payload=%h required valid=1 port=%0d payload=%h",
                 c, out_valid, out_port, out_pkt.payload, ep, epl);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push(2, 16'h0200);
    push(3, 16'h0300);
    push(4, 16'h0400);
    tick();
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (egress_deq !== 8'h00) begin
        errors++; $display("FAIL bp_deq[%0d] got=%b required=00000000", c, egress_deq);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_port !== 3'd2 || out_pkt.payload !== 16'h0200) begin
        errors++;
        $display("FAIL bp_hold[%0d] valid=%b port=%0d payload=%h required valid=1 port=2 payload=0200",
                 c, out_valid, out_port, out_pkt.payload);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_port !== 3'd3 || out_pkt.payload !== 16'h0300) begin
      errors++;
      $display("FAIL bp_release1 valid=%b port=%0d payload=%h required valid=1 port=3 payload=0300",
               out_valid, out_port, out_pkt.payload);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_port !== 3'd4 || out_pkt.payload !== 16'h0400) begin
      errors++;
      $display("FAIL bp_release2 valid=%b port=%0d payload=%h required valid=1 port=4 payload=0400",
               out_valid, out_port, out_pkt.payload);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_empty got=%b required=0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    push(1, 16'h0110);
    push(5, 16'h0550);
    push(7, 16'h0770);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_port !== 3'd5) begin
      errors++; $display("FAIL mid_pre valid=%b port=%0d required valid=1 port=5", out_valid, out_port);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (egress_deq !== 8'h00) begin
      errors++; $display("FAIL mid_rst_deq got=%b required=00000000", egress_deq);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_pkt !== packet_t'('0)) begin
      errors++; $display("FAIL mid_rst_out valid=%b pkt=%h required valid=0 pkt=0", out_valid, out_pkt);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (egress_deq !== 8'h02) begin
      errors++; $display("FAIL mid_ptr_zero deq=%b required=00000010", egress_deq);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_port !== 3'd1 || out_pkt.payload !== 16'h0110) begin
      errors++;
      $display("FAIL mid_resume1 valid=%b port=%0d payload=%h required valid=1 port=1 payload=0110",
               out_valid, out_port, out_pkt.payload);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_port !== 3'd7 || out_pkt.payload !== 16'h0770) begin
      errors++;
      $display("FAIL mid_resume2 valid=%b port=%0d payload=%h required valid=1 port=7 payload=0770",
               out_valid, out_port, out_pkt.payload);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_empty got=%b required=0", out_valid);
    end
  endtask

`ifdef CLUSTER_EGRESS_STATS_EN
  task automatic test_stats();
    stat_sel = 3'd0;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) push(6, 16'h0e00 + 16'(k));
    repeat (21) tick();
    stat_sel = 3'd6;
    #1;
    checks++;
    if (stat_count !== 4'd15) begin
      errors++; $display("FAIL stats_sat got=%0d required=15", stat_count);
    end
    stat_sel = 3'd0;
    #1;
    checks++;
    if (stat_count !== 4'd0) begin
      errors++; $display("FAIL stats_zero got=%0d required=0", stat_count);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
`ifdef CLUSTER_EGRESS_STATS_EN
    stat_sel = 3'd0;
`endif
    refresh();
    test_reset();
    test_single();
    test_all_ports();
    test_fairness();
    test_backpressure();
    test_reset_mid();
`ifdef CLUSTER_EGRESS_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
